// File: rtl/ttl_cengen_sync.sv
// ttl_cengen_sync
// ---------------------------------------------------------------------------
// Source side of the Cen edge-detect protocol used by the synchronous TTL
// models. A fractional NUM/DEN accumulator decides on which Clk edges the
// registered pseudo-clock level Cen_out toggles, so Cen_out toggles at
// Clk*NUM/DEN. Downstream sync flops sample Cen_out every Clk and act on its
// 0->1 transition. Rise/Fall strobes and a half-rate clock Div2_out are
// registered on the same edge as Cen_out.
//
// Parameters
//   W   : accumulator width (DEN must be < 2^(W-1))
//   NUM : increment per Clk (1 <= NUM <= DEN)
//   DEN : accumulator modulus
//
// Ports
//   Clk      in  master clock, rising edge
//   Rst_n    in  asynchronous active-low reset
//   Run      in  1 = generate, 0 = stop with Cen_out parked low
//   Sync     in  phase realign (clears phase and Div2_out), overrides Run
//   Cen_out  out pseudo-clock level
//   Rise     out one-cycle strobe in the first cycle Cen_out reads 1
//   Fall     out one-cycle strobe in the first cycle Cen_out reads 0
//   Div2_out out toggles on every Cen_out rise
//
// Control priority on each Clk edge: Sync, then Run=0, then accumulate.
// All outputs are flops; there is no combinational input-to-output path.
// ---------------------------------------------------------------------------
module ttl_cengen_sync #(
  parameter int W   = 16,
  parameter int NUM = 1,
  parameter int DEN = 4
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic Run,
  input  logic Sync,
  output logic Cen_out,
  output logic Rise,
  output logic Fall,
  output logic Div2_out
);

  localparam logic [W:0] NUM_X = (W+1)'(NUM);
  localparam logic [W:0] DEN_X = (W+1)'(DEN);

  logic [W-1:0] acc;
  logic [W:0]   sum;       // one bit wider so acc + NUM can never wrap
  logic         toggle;
  logic [W-1:0] acc_next;

  always_comb begin
    sum      = {1'b0, acc} + NUM_X;
    toggle   = (sum >= DEN_X);
    // When not toggling, sum < DEN < 2^(W-1), so dropping the top bit is safe.
    acc_next = toggle ? W'(sum - DEN_X) : sum[W-1:0];
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      acc      <= '0;
      Cen_out  <= 1'b0;
      Rise     <= 1'b0;
      Fall     <= 1'b0;
      Div2_out <= 1'b0;
    end else if (Sync) begin
      // Realign: behaves like a fresh start, but still reports the falling
      // level if Cen_out was high so downstream logic sees a clean Fall.
      acc      <= '0;
      Cen_out  <= 1'b0;
      Rise     <= 1'b0;
      Fall     <= Cen_out;
      Div2_out <= 1'b0;
    end else if (!Run) begin
      // Stopped: park low, keep Div2_out phase across the stop.
      acc      <= '0;
      Cen_out  <= 1'b0;
      Rise     <= 1'b0;
      Fall     <= Cen_out;
    end else if (toggle) begin
      acc      <= acc_next;
      Cen_out  <= ~Cen_out;
      Rise     <= ~Cen_out;
      Fall     <= Cen_out;
      if (!Cen_out) begin
        Div2_out <= ~Div2_out;   // new level is 1: this edge is a rise
      end
    end else begin
      acc      <= acc_next;
      Rise     <= 1'b0;
      Fall     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ttl_cengen_sync.sv
// tb_ttl_cengen_sync
// ---------------------------------------------------------------------------
// Three instances with different NUM/DEN share Clk, Rst_n, Run and Sync:
//   a: NUM=1 DEN=4   b: NUM=3 DEN=8   c: NUM=5 DEN=5
// The reference model describes each generator by the number of Clk edges k
// since its phase started: the toggle count is floor(k*NUM/DEN), the level is
// its parity, Div2_out follows the count of rises, and the strobes are the
// level transitions. Each edge the model pushes the expected 12-bit output
// vector {a,b,c} x {Cen,Rise,Fall,Div2} into exp_q; the checker pops on the
// falling edge and compares with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_ttl_cengen_sync;

  logic clk;
  logic rst_n;
  logic run;
  logic sync;

  logic cen_a, rise_a, fall_a, div_a;
  logic cen_b, rise_b, fall_b, div_b;
  logic cen_c, rise_c, fall_c, div_c;

  int checks = 0;
  int errors = 0;

  logic [11:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  ttl_cengen_sync #(.W(16), .NUM(1), .DEN(4)) u_a (
    .Clk(clk), .Rst_n(rst_n), .Run(run), .Sync(sync),
    .Cen_out(cen_a), .Rise(rise_a), .Fall(fall_a), .Div2_out(div_a)
  );
  ttl_cengen_sync #(.W(16), .NUM(3), .DEN(8)) u_b (
    .Clk(clk), .Rst_n(rst_n), .Run(run), .Sync(sync),
    .Cen_out(cen_b), .Rise(rise_b), .Fall(fall_b), .Div2_out(div_b)
  );
  ttl_cengen_sync #(.W(16), .NUM(5), .DEN(5)) u_c (
    .Clk(clk), .Rst_n(rst_n), .Run(run), .Sync(sync),
    .Cen_out(cen_c), .Rise(rise_c), .Fall(fall_c), .Div2_out(div_c)
  );

  function automatic logic [11:0] dut_vec();
    return {cen_a, rise_a, fall_a, div_a,
            cen_b, rise_b, fall_b, div_b,
            cen_c, rise_c, fall_c, div_c};
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [11:0] got,
                       input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%03h exp=%03h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int    m_num[3] = '{1, 3, 5};
  int    m_den[3] = '{4, 8, 5};
  longint m_k[3];
  bit    m_base[3];   // Div2 phase at the start of the current run
  bit    m_cen[3];
  bit    m_div[3];

  always @(posedge clk or negedge rst_n) begin
    logic [11:0] e;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_k[i] = 0; m_base[i] = 0; m_cen[i] = 0; m_div[i] = 0;
      end
      exp_q.delete();
    end else begin
      e = '0;
      for (int i = 0; i < 3; i++) begin
        bit c, r, f, d;
        longint t;
        if (sync) begin
          m_k[i] = 0; m_base[i] = 0;
          c = 0; d = 0; r = 0; f = m_cen[i];
        end else if (!run) begin
          m_k[i] = 0; m_base[i] = m_div[i];
          c = 0; d = m_div[i]; r = 0; f = m_cen[i];
        end else begin
          m_k[i] = m_k[i] + 1;
          t = (m_k[i] * m_num[i]) / m_den[i];
          c = t[0];
          d = m_base[i] ^ (((t + 1) / 2) % 2 == 1);
          r = !m_cen[i] && c;
          f = m_cen[i] && !c;
        end
        m_cen[i] = c;
        m_div[i] = d;
        e[11 - 4*i -: 4] = {c, r, f, d};
      end
      exp_q.push_back(e);
    end
  end

  // Scoreboard: compare each edge's result on the following falling edge.
  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) begin
      check("edge", dut_vec(), exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Count falling edges until rise_a shows, bounded.
  task automatic edges_to_rise_a(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (rise_a) return;
    end
    n = -1;
  endtask

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      run  = ($urandom_range(0, 9) != 0);
      sync = ($urandom_range(0, 24) == 0);
    end
    @(negedge clk);
    run  = 1'b1;
    sync = 1'b0;
  endtask

  // ---------------- main ----------------
  initial begin
    int n;
    rst_n = 1'b0;
    run   = 1'b0;
    sync  = 1'b0;
    #2;
    check("reset_state", dut_vec(), 12'h000);

    // Release with Run=1: first rise of instance a on the 4th edge.
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run   = 1'b1;
    edges_to_rise_a(n);
    check("first_rise_a", 12'(n), 12'd4);
    idle_cycles(100);

    random_phase(300);
    idle_cycles(20);

    // Drop Run two cycles after a rise of instance a, then restart.
    edges_to_rise_a(n);
    check("rise_seen_before_stop", 12'(n >= 1), 12'd1);
    idle_cycles(1);
    run = 1'b0;
    idle_cycles(5);
    run = 1'b1;
    edges_to_rise_a(n);
    check("restart_rise_a", 12'(n), 12'd4);

    // One-cycle Sync mid-period, then a long steady run.
    idle_cycles(10);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    edges_to_rise_a(n);
    check("post_sync_rise_a", 12'(n), 12'd4);
    idle_cycles(800);

    // Asynchronous reset between edges while instance a is high.
    n = 0;
    while (!cen_a && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("cen_a_high_before_reset", 12'(cen_a), 12'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", dut_vec(), 12'h000);
    @(negedge clk);
    check("held_reset", dut_vec(), 12'h000);
    rst_n = 1'b1;
    edges_to_rise_a(n);
    check("rise_after_reset", 12'(n), 12'd4);
    idle_cycles(50);

    random_phase(200);
    idle_cycles(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
